// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the BCD score counter:
//   BCD_W       - bits per packed-BCD digit
//   BCD_MAX     - largest legal digit value
//   SCORE_WRAP  - overflow mode: score wraps modulo 10^DIGITS
//   SCORE_SAT   - overflow mode: score holds at all-nines
//   bin_to_bcd  - converts a binary constant into packed BCD (8 digits) so
//                 parameters such as the bonus value can be turned into a
//                 BCD addend at elaboration time.
// ---------------------------------------------------------------------------
package score_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         SCORE_WRAP = 0;
    localparam int         SCORE_SAT  = 1;
    localparam int         MAX_DIGITS = 8;

    // Binary to packed BCD, digit 0 in bits [3:0]. Values of 10^8 and above
    // lose their upper digits; callers keep the argument in range.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] bin_to_bcd(input int unsigned value);
        logic [BCD_W*MAX_DIGITS-1:0] res;
        int unsigned                 rem;
        res = '0;
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            res[i*BCD_W +: BCD_W] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder with decimal adjust. One instance per
// score digit; the instances are chained through cin/cout to form a
// digit-serial ripple adder.
// Ports:
//   a    in  4  augend digit (0-9)
//   b    in  4  addend digit (0-9)
//   cin  in  1  carry from the next-lower digit
//   sum  out 4  result digit (0-9)
//   cout out 1  carry into the next-higher digit
// ---------------------------------------------------------------------------
module bcd_digit_add
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        sum  = raw[BCD_W-1:0];
        cout = 1'b0;
        // Largest raw value is 9+9+1 = 19. Anything above 9 wraps by ten;
        // adding 6 and dropping bit 4 is the same as subtracting 10.
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = raw[BCD_W-1:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_counter_bcd.sv
// ---------------------------------------------------------------------------
// score_counter_bcd
// Game score counter with packed-BCD output. While running (start && !pause)
// it adds one point every PERIOD cycles of clk3 and BONUS_PTS on each bonus
// pulse, flags a change of the milestone digit, and raises a sticky overflow
// flag when the score carries out of the top digit.
//
// Optional feature macro: SCORE_HISCORE_EN
//   defined   - hiscore register and comparator are built; hiscore survives
//               clear and is lost only on reset.
//   undefined - hiscore is tied to zero.
//
// Parameters:
//   DIGITS          number of BCD digits (1-8)
//   PERIOD          running cycles per point (>= 1)
//   BONUS_PTS       points per bonus pulse (< 10^DIGITS)
//   SATURATE        SCORE_WRAP (0) or SCORE_SAT (1)
//   MILESTONE_DIGIT digit index watched for milestone (< DIGITS)
//
// Ports:
//   clk3      in   1         frame clock
//   reset     in   1         asynchronous, active-low reset
//   start     in   1         game running
//   pause     in   1         freeze scoring while high
//   clear     in   1         synchronous new-game clear (highest priority)
//   bonus     in   1         single-cycle bonus request
//   score     out  4*DIGITS  packed BCD score, digit 0 in [3:0]
//   milestone out  1         one-cycle pulse when the milestone digit changes
//   ovf       out  1         sticky overflow flag
//   hiscore   out  4*DIGITS  packed BCD high score
// ---------------------------------------------------------------------------
module score_counter_bcd
    import score_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int PERIOD          = 10,
    parameter int BONUS_PTS       = 25,
    parameter int SATURATE        = 0,
    parameter int MILESTONE_DIGIT = 2
) (
    input  logic                    clk3,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    input  logic                    bonus,
    output logic [BCD_W*DIGITS-1:0] score,
    output logic                    milestone,
    output logic                    ovf,
    output logic [BCD_W*DIGITS-1:0] hiscore
);

    localparam int SW   = BCD_W * DIGITS;
    localparam int FC_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(PERIOD - 1);

    // Bonus value in packed BCD, built once at elaboration.
    localparam logic [BCD_W*MAX_DIGITS-1:0] BONUS_BCD_FULL = bin_to_bcd(BONUS_PTS);
    localparam logic [SW-1:0]               BONUS_BCD      = BONUS_BCD_FULL[SW-1:0];
    localparam logic [SW-1:0]               ALL_NINES      = {DIGITS{BCD_MAX}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [SW-1:0]   score_q,     score_d;
    logic            ovf_q,       ovf_d;
    logic            milestone_q, milestone_d;

    // ------------------------------------------------------------------
    // Tick / bonus qualification
    // ------------------------------------------------------------------
    logic running;
    logic tick;
    logic bonus_take;
    logic add_en;

    assign running    = start && !pause;
    assign tick       = running && (frame_cnt_q == FC_LAST);
    assign bonus_take = running && bonus;
    assign add_en     = tick || bonus_take;

    // ------------------------------------------------------------------
    // Ripple BCD adder. The tick point enters as the carry into digit 0,
    // so a tick coinciding with a bonus adds 1+BONUS_PTS in one pass.
    // ------------------------------------------------------------------
    logic [SW-1:0]   addend;
    logic [SW-1:0]   sum_w;
    logic [DIGITS:0] carry;

    assign addend   = bonus_take ? BONUS_BCD : '0;
    assign carry[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_add u_digit (
            .a    (score_q[g*BCD_W +: BCD_W]),
            .b    (addend[g*BCD_W +: BCD_W]),
            .cin  (carry[g]),
            .sum  (sum_w[g*BCD_W +: BCD_W]),
            .cout (carry[g+1])
        );
    end

    logic carry_out;
    assign carry_out = carry[DIGITS];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        score_d     = score_q;
        ovf_d       = ovf_q;
        milestone_d = 1'b0;

        if (clear) begin
            // Clear wins over any tick or bonus in the same cycle.
            frame_cnt_d = '0;
            score_d     = '0;
            ovf_d       = 1'b0;
        end else begin
            // Counter only moves while running, so a pause resumes
            // mid-period instead of restarting the frame.
            if (running) begin
                frame_cnt_d = tick ? '0 : frame_cnt_q + FC_W'(1);
            end

            if (add_en) begin
                if (carry_out) begin
                    ovf_d   = 1'b1;
                    score_d = (SATURATE == SCORE_SAT) ? ALL_NINES : sum_w;
                end else begin
                    score_d = sum_w;
                end

                // Once saturated the score is pinned, whatever the adder says.
                if ((SATURATE == SCORE_SAT) && ovf_q) begin
                    score_d = score_q;
                end

                milestone_d = (score_d[MILESTONE_DIGIT*BCD_W +: BCD_W] !=
                               score_q[MILESTONE_DIGIT*BCD_W +: BCD_W]);
            end
        end
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            score_q     <= '0;
            ovf_q       <= 1'b0;
            milestone_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            score_q     <= score_d;
            ovf_q       <= ovf_d;
            milestone_q <= milestone_d;
        end
    end

    assign score     = score_q;
    assign ovf       = ovf_q;
    assign milestone = milestone_q;

    // ------------------------------------------------------------------
    // Optional high score. Compares the registered score, so hiscore
    // follows a new maximum one cycle later. Packed BCD orders the same
    // as the decimal value, so a plain unsigned compare is enough.
    // ------------------------------------------------------------------
`ifdef SCORE_HISCORE_EN
    logic [SW-1:0] hiscore_q, hiscore_d;

    always_comb begin
        hiscore_d = hiscore_q;
        if (score_q > hiscore_q) begin
            hiscore_d = score_q;
        end
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = '0;
`endif

endmodule

// File: tb/tb_score_counter_bcd.sv
// ---------------------------------------------------------------------------
// tb_score_counter_bcd
// Drives a wrapping and a saturating instance (DIGITS=4, PERIOD=4,
// BONUS_PTS=25, MILESTONE_DIGIT=2) with the same stimulus and checks both
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_score_counter_bcd;

    logic        clk3  = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic        bonus = 1'b0;

    logic [15:0] score_w, hi_w, score_s, hi_s;
    logic        ms_w, ovf_w, ms_s, ovf_s;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    score_counter_bcd #(
        .DIGITS(4), .PERIOD(4), .BONUS_PTS(25), .SATURATE(0), .MILESTONE_DIGIT(2)
    ) dut_wrap (
        .clk3(clk3), .reset(reset), .start(start), .pause(pause),
        .clear(clear), .bonus(bonus),
        .score(score_w), .milestone(ms_w), .ovf(ovf_w), .hiscore(hi_w)
    );

    score_counter_bcd #(
        .DIGITS(4), .PERIOD(4), .BONUS_PTS(25), .SATURATE(1), .MILESTONE_DIGIT(2)
    ) dut_sat (
        .clk3(clk3), .reset(reset), .start(start), .pause(pause),
        .clear(clear), .bonus(bonus),
        .score(score_s), .milestone(ms_s), .ovf(ovf_s), .hiscore(hi_s)
    );

    // ---------------- clock ----------------
    always #5 clk3 = ~clk3;

    // ---------------- vector table ----------------
    typedef struct {
        logic        start, pause, clear, bonus;
        logic [15:0] exp_sw;
        logic        exp_mw, exp_ow;
        logic [15:0] exp_ss;
        logic        exp_ms, exp_os;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic st, input logic pa, input logic cl, input logic bo,
                           input logic [15:0] sw, input logic mw, input logic ow,
                           input logic [15:0] ss, input logic ms, input logic os);
        vec_t v;
        v.start = st; v.pause = pa; v.clear = cl; v.bonus = bo;
        v.exp_sw = sw; v.exp_mw = mw; v.exp_ow = ow;
        v.exp_ss = ss; v.exp_ms = ms; v.exp_os = os;
        vq.push_back(v);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hi_exp(input logic [15:0] v);
        return HI_EN ? v : 16'h0000;
    endfunction

    function automatic logic [15:0] to_bcd16(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge, outputs are sampled
    // at the same point after the following edge.
    task automatic step(input logic st, input logic pa, input logic cl, input logic bo);
        start = st; pause = pa; clear = cl; bonus = bo;
        @(posedge clk3);
        #1;
        bonus = 1'b0;
        clear = 1'b0;
    endtask

    task automatic run(input int n, input logic bo);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, bo);
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].start, vq[i].pause, vq[i].clear, vq[i].bonus);
            chk({nm, "_score_w"}, score_w, vq[i].exp_sw);
            chk({nm, "_ms_w"},    16'(ms_w),  16'(vq[i].exp_mw));
            chk({nm, "_ovf_w"},   16'(ovf_w), 16'(vq[i].exp_ow));
            chk({nm, "_score_s"}, score_s, vq[i].exp_ss);
            chk({nm, "_ms_s"},    16'(ms_s),  16'(vq[i].exp_ms));
            chk({nm, "_ovf_s"},   16'(ovf_s), 16'(vq[i].exp_os));
        end
        vq.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_score_w"}, score_w, 16'h0000);
        chk({nm, "_ms_w"},    16'(ms_w), 16'h0);
        chk({nm, "_ovf_w"},   16'(ovf_w), 16'h0);
        chk({nm, "_hi_w"},    hi_w, 16'h0000);
        chk({nm, "_score_s"}, score_s, 16'h0000);
        chk({nm, "_ms_s"},    16'(ms_s), 16'h0);
        chk({nm, "_ovf_s"},   16'(ovf_s), 16'h0);
        chk({nm, "_hi_s"},    hi_s, 16'h0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #12;
        chk_all_zero("reset");
        @(posedge clk3);
        #1;
        reset = 1'b1;

        // Basic tick: one point every 4 running edges, first at edge 4
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk("tick_score_w", score_w, to_bcd16(i / 4));
            chk("tick_score_s", score_s, to_bcd16(i / 4));
            chk("tick_ms_w", 16'(ms_w), 16'h0);
        end

        // Pause at frame_cnt=2, bonus while paused / stopped is ignored
        add_vec(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0010, 0, 0);   // fc=1
        add_vec(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0010, 0, 0);   // fc=2
        for (int i = 0; i < 7; i++)
            add_vec(1, 1, 0, 1, 16'h0010, 0, 0, 16'h0010, 0, 0);
        add_vec(0, 0, 0, 1, 16'h0010, 0, 0, 16'h0010, 0, 0);   // not started
        add_vec(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0010, 0, 0);   // fc=3
        add_vec(1, 0, 0, 0, 16'h0011, 0, 0, 16'h0011, 0, 0);   // tick
        run_table("pause");

        // BCD carry + milestone: 11 -> 98 by 87 ticks, then tick+bonus
        run(348, 1'b0);
        chk("preload_98", score_w, 16'h0098);
        run(3, 1'b0);
        chk("preload_98_fc3", score_w, 16'h0098);
        add_vec(1, 0, 0, 1, 16'h0124, 1, 0, 16'h0124, 1, 0);
        add_vec(1, 0, 0, 0, 16'h0124, 0, 0, 16'h0124, 0, 0);
        run_table("carry");
        chk("hi_after_124", hi_w, hi_exp(16'h0124));

        // Clear, then climb to 9990: 98 frames of bonus every edge (+101 each),
        // three more bonuses, a bare tick, then 16 plain ticks.
        add_vec(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        run_table("clear1");
        chk("hi_kept_clear1", hi_w, hi_exp(16'h0124));
        run(392, 1'b1);
        chk("climb_9898", score_w, 16'h9898);
        run(3, 1'b1);
        run(1, 1'b0);
        run(64, 1'b0);
        chk("climb_9990_w", score_w, 16'h9990);
        chk("climb_9990_s", score_s, 16'h9990);
        chk("climb_ovf_w", 16'(ovf_w), 16'h0);
        chk("hi_lag_9989", hi_w, hi_exp(16'h9989));

        // Overflow: wrap -> 0015 with milestone, saturate -> 9999
        add_vec(1, 0, 0, 1, 16'h0015, 1, 1, 16'h9999, 0, 1);
        add_vec(1, 0, 0, 1, 16'h0040, 0, 1, 16'h9999, 0, 1);
        add_vec(1, 0, 0, 0, 16'h0040, 0, 1, 16'h9999, 0, 1);
        add_vec(1, 0, 0, 0, 16'h0041, 0, 1, 16'h9999, 0, 1);
        run_table("ovf");
        chk("hi_w_9990", hi_w, hi_exp(16'h9990));
        chk("hi_s_9999", hi_s, hi_exp(16'h9999));

        // Asynchronous reset mid-period discards the partial frame count
        run(1, 1'b0);
        start = 1'b0;
        reset = 1'b0;
        #2;
        chk_all_zero("async_reset");
        @(posedge clk3);
        #1;
        reset = 1'b1;
        run(3, 1'b0);
        chk("post_reset_edge3", score_w, 16'h0000);
        run(1, 1'b0);
        chk("post_reset_edge4", score_w, 16'h0001);

        // Build 0042, then clear together with tick and bonus
        run(1, 1'b1);
        chk("bonus_26", score_w, 16'h0026);
        run(3, 1'b0);
        run(60, 1'b0);
        run(3, 1'b0);
        chk("score_42_w", score_w, 16'h0042);
        chk("score_42_s", score_s, 16'h0042);
        chk("hi_42", hi_w, hi_exp(16'h0042));
        add_vec(1, 0, 1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0);
        add_vec(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        run_table("clear_prio");
        chk("hi_kept_clear2", hi_w, hi_exp(16'h0042));
        reset = 1'b0;
        #2;
        chk("hi_reset", hi_w, 16'h0000);
        chk("hi_reset_s", hi_s, 16'h0000);
        reset = 1'b1;

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
